// File: rtl/mlp_conv_pkg.sv
// Shared constants, FSM state type and quantizer for mlp_conv.
// Used by both the input controllers and the output controller.
package mlp_conv_pkg;

  localparam int OUTPUT_WIDTH = 32;
  localparam int OS_WIDTH     = 40;
  localparam int OS_DEPTH     = 5;
  localparam int HEAD_BITS    = OS_WIDTH - OUTPUT_WIDTH + 1;

  typedef enum logic {
    IDLE,
    DRAIN
  } os_state_t;

  // Arithmetic right shift, then clamp into the signed 32-bit range.
  function automatic logic [OUTPUT_WIDTH-1:0] sat_shift(
    input logic signed [OS_WIDTH-1:0] v,
    input logic        [4:0]          sh
  );
    logic signed [OS_WIDTH-1:0] t;
    logic        [HEAD_BITS-1:0] head;
    t    = v >>> sh;
    head = t[OS_WIDTH-1:OUTPUT_WIDTH-1];
    if (head == {HEAD_BITS{t[OS_WIDTH-1]}})
      return t[OUTPUT_WIDTH-1:0];
    else if (t[OS_WIDTH-1])
      return {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};
    else
      return {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Show-ahead synchronous FIFO with flush, count, full and empty.
// Full/empty are registered from the next-cycle count.
module sync_fifo_fwft #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      next_count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Occupancy after this cycle's accepted push/pop.
  always_comb begin
    next_count = count;
    unique case ({do_push, do_pop})
      2'b10:   next_count = count + 1'b1;
      2'b01:   next_count = count - 1'b1;
      default: next_count = count;
    endcase
  end

  // Pointers, count and registered flags; flush wins over traffic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= next_count;
      full  <= (next_count == (AW+1)'(DEPTH));
      empty <= (next_count == '0);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/output_act_out_ctrl.sv
// Captures a row of accumulator lanes, quantizes each one and
// serializes the row into a show-ahead FIFO for the host reader.
module output_act_out_ctrl
  import mlp_conv_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                    CLK,
  input  logic                    RESETN,
  input  logic                    CLEAR_FIFO,
  input  logic                    LOAD_OS,
  input  logic [OS_WIDTH-1:0]     OS_WR_DATA_0,
  input  logic [OS_WIDTH-1:0]     OS_WR_DATA_1,
  input  logic [OS_WIDTH-1:0]     OS_WR_DATA_2,
  input  logic [OS_WIDTH-1:0]     OS_WR_DATA_3,
  input  logic [OS_WIDTH-1:0]     OS_WR_DATA_4,
  input  logic [3:0]              PARAM_K,
  input  logic [4:0]              PARAM_SHIFT,
  output logic                    OS_BUSY,
  input  logic                    FIFO_RD_CMD,
  output logic [OUTPUT_WIDTH-1:0] FIFO_RD_DATA,
  output logic                    FIFO_EMPTY,
  output logic                    FIFO_FULL
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  os_state_t                  state;
  logic [OS_WIDTH-1:0]        lane_q [OS_DEPTH];
  logic [2:0]                 k_q;
  logic [4:0]                 sh_q;
  logic [2:0]                 idx;
  logic                       load_q;
  logic                       load_ev;
  logic                       busy;
  logic [2:0]                 k_eff;
  logic [OS_WIDTH-1:0]        lane_sel;
  logic [OUTPUT_WIDTH-1:0]    quant;
  logic                       push;
  logic                       last;
  logic [CW-1:0]              fifo_count;

  assign load_ev = LOAD_OS & ~load_q;
  assign k_eff   = (PARAM_K > 4'd5) ? 3'd5 : PARAM_K[2:0];
  assign last    = (idx == k_q - 3'd1);
  assign push    = (state == DRAIN) & ~FIFO_FULL & ~CLEAR_FIFO;
  assign OS_BUSY = busy;

  // Lane mux feeding the quantizer.
  always_comb begin
    lane_sel = lane_q[0];
    unique case (idx)
      3'd1:    lane_sel = lane_q[1];
      3'd2:    lane_sel = lane_q[2];
      3'd3:    lane_sel = lane_q[3];
      3'd4:    lane_sel = lane_q[4];
      default: lane_sel = lane_q[0];
    endcase
  end

  assign quant = sat_shift(lane_sel, sh_q);

  // Edge detect, row capture and drain sequencing.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state  <= IDLE;
      idx    <= '0;
      load_q <= 1'b0;
      busy   <= 1'b0;
      k_q    <= '0;
      sh_q   <= '0;
      for (int i = 0; i < OS_DEPTH; i++) lane_q[i] <= '0;
    end else begin
      load_q <= LOAD_OS;
      if (CLEAR_FIFO) begin
        state <= IDLE;
        idx   <= '0;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (load_ev && PARAM_K != 4'd0) begin
              lane_q[0] <= OS_WR_DATA_0;
              lane_q[1] <= OS_WR_DATA_1;
              lane_q[2] <= OS_WR_DATA_2;
              lane_q[3] <= OS_WR_DATA_3;
              lane_q[4] <= OS_WR_DATA_4;
              k_q       <= k_eff;
              sh_q      <= PARAM_SHIFT;
              idx       <= '0;
              busy      <= 1'b1;
              state     <= DRAIN;
            end
          end
          DRAIN: begin
            if (!FIFO_FULL) begin
              if (last) begin
                idx   <= '0;
                busy  <= 1'b0;
                state <= IDLE;
              end else begin
                idx <= idx + 3'd1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  sync_fifo_fwft #(
    .WIDTH (OUTPUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RESETN),
    .clear (CLEAR_FIFO),
    .push  (push),
    .wdata (quant),
    .pop   (FIFO_RD_CMD),
    .rdata (FIFO_RD_DATA),
    .count (fifo_count),
    .full  (FIFO_FULL),
    .empty (FIFO_EMPTY)
  );

  // Full flag must always agree with the occupancy counter.
  assert property (@(posedge CLK) disable iff (!RESETN)
    FIFO_FULL == (fifo_count == CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_output_act_out_ctrl.sv
// Self-checking bench for output_act_out_ctrl.
// Vector table plus scoreboarded multi-cycle sequences.
module tb_output_act_out_ctrl;

  logic        CLK = 1'b0;
  logic        RESETN = 1'b0;
  logic        CLEAR_FIFO = 1'b0;
  logic        LOAD_OS = 1'b0;
  logic        FIFO_RD_CMD = 1'b0;
  logic [3:0]  PARAM_K = '0;
  logic [4:0]  PARAM_SHIFT = '0;
  logic [39:0] lanes [5];
  logic        OS_BUSY;
  logic [31:0] FIFO_RD_DATA;
  logic        FIFO_EMPTY;
  logic        FIFO_FULL;

  typedef struct {
    logic [39:0] lane;
    logic [4:0]  sh;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl [16];
  logic [31:0] sbq [$];
  int          n_vec = 0;
  int          n_bad = 0;

  always #5 CLK = ~CLK;

  output_act_out_ctrl dut (
    .CLK          (CLK),
    .RESETN       (RESETN),
    .CLEAR_FIFO   (CLEAR_FIFO),
    .LOAD_OS      (LOAD_OS),
    .OS_WR_DATA_0 (lanes[0]),
    .OS_WR_DATA_1 (lanes[1]),
    .OS_WR_DATA_2 (lanes[2]),
    .OS_WR_DATA_3 (lanes[3]),
    .OS_WR_DATA_4 (lanes[4]),
    .PARAM_K      (PARAM_K),
    .PARAM_SHIFT  (PARAM_SHIFT),
    .OS_BUSY      (OS_BUSY),
    .FIFO_RD_CMD  (FIFO_RD_CMD),
    .FIFO_RD_DATA (FIFO_RD_DATA),
    .FIFO_EMPTY   (FIFO_EMPTY),
    .FIFO_FULL    (FIFO_FULL)
  );

  function automatic logic [31:0] model(input logic [39:0] lane,
                                        input int sh);
    longint v;
    v = longint'($signed(lane));
    v = v >>> sh;
    if (v > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (v < -64'sd2147483648) return 32'h8000_0000;
    return v[31:0];
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_row(input int k, input int sh, input bit use_model);
    int kk;
    PARAM_K     = 4'(k);
    PARAM_SHIFT = 5'(sh);
    LOAD_OS     = 1'b1;
    tick();
    LOAD_OS     = 1'b0;
    if (use_model) begin
      kk = (k > 5) ? 5 : k;
      for (int i = 0; i < kk; i++) sbq.push_back(model(lanes[i], sh));
    end
  endtask

  task automatic wait_idle(input string nm);
    int c = 0;
    while (OS_BUSY && c < 200) begin
      tick();
      c++;
    end
    check({nm, "_idle"}, 32'(OS_BUSY), 32'd0);
  endtask

  task automatic read_word(input string nm);
    int c = 0;
    logic [31:0] e;
    while (FIFO_EMPTY && c < 50) begin
      tick();
      c++;
    end
    check({nm, "_avail"}, 32'(FIFO_EMPTY), 32'd0);
    e = (sbq.size() > 0) ? sbq.pop_front() : 32'hDEAD_BEEF;
    if (!FIFO_EMPTY) begin
      check(nm, FIFO_RD_DATA, e);
      FIFO_RD_CMD = 1'b1;
      tick();
      FIFO_RD_CMD = 1'b0;
    end
  endtask

  task automatic drain_all(input string nm);
    while (sbq.size() > 0) read_word(nm);
  endtask

  task automatic rand_lanes();
    for (int i = 0; i < 5; i++)
      lanes[i] = {8'($urandom), 32'($urandom)};
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    tbl[0]  = '{40'h00_0000_0005, 5'd0,  32'h0000_0005};
    tbl[1]  = '{40'hFF_FFFF_FFFE, 5'd0,  32'hFFFF_FFFE};
    tbl[2]  = '{40'h00_1234_5678, 5'd0,  32'h1234_5678};
    tbl[3]  = '{40'h01_0000_0000, 5'd0,  32'h7FFF_FFFF};
    tbl[4]  = '{40'h80_0000_0000, 5'd0,  32'h8000_0000};
    tbl[5]  = '{40'h01_0000_0000, 5'd8,  32'h0100_0000};
    tbl[6]  = '{40'h00_7FFF_FFFF, 5'd0,  32'h7FFF_FFFF};
    tbl[7]  = '{40'hFF_8000_0000, 5'd0,  32'h8000_0000};
    tbl[8]  = '{40'hFF_7FFF_FFFF, 5'd0,  32'h8000_0000};
    tbl[9]  = '{40'h80_0000_0000, 5'd31, 32'hFFFF_FF00};
    tbl[10] = '{40'h7F_FFFF_FFFF, 5'd31, 32'h0000_00FF};
    tbl[11] = '{40'hFF_FFFF_FFFF, 5'd31, 32'hFFFF_FFFF};
    tbl[12] = '{40'h00_0000_0100, 5'd4,  32'h0000_0010};
    tbl[13] = '{40'h7F_FFFF_FFFF, 5'd7,  32'h7FFF_FFFF};
    tbl[14] = '{40'h7F_FFFF_FFFF, 5'd8,  32'h7FFF_FFFF};
    tbl[15] = '{40'h80_0000_0000, 5'd8,  32'h8000_0000};
    for (int i = 0; i < 5; i++) lanes[i] = '0;

    // reset
    tick();
    tick();
    check("rst_empty", 32'(FIFO_EMPTY), 32'd1);
    check("rst_full", 32'(FIFO_FULL), 32'd0);
    check("rst_busy", 32'(OS_BUSY), 32'd0);
    check("rst_data", FIFO_RD_DATA, 32'd0);
    RESETN = 1'b1;
    tick();

    // quantizer vector table, one K=1 row each
    for (int i = 0; i < 16; i++) begin
      lanes[0] = tbl[i].lane;
      load_row(1, int'(tbl[i].sh), 1'b0);
      sbq.push_back(tbl[i].exp);
      wait_idle("vec");
      read_word($sformatf("vec%0d", i));
    end

    // basic row with latency and busy length
    lanes[0] = 40'h00_0000_0005;
    lanes[1] = 40'hFF_FFFF_FFFE;
    lanes[2] = 40'h00_1234_5678;
    load_row(3, 0, 1'b1);
    check("basic_busy_on", 32'(OS_BUSY), 32'd1);
    check("basic_empty_n", 32'(FIFO_EMPTY), 32'd1);
    tick();
    check("basic_empty_n1", 32'(FIFO_EMPTY), 32'd0);
    cnt = 1;
    while (OS_BUSY && cnt < 20) begin
      tick();
      cnt++;
    end
    check("basic_busy_len", 32'(cnt), 32'd3);
    drain_all("basic");
    check("basic_empty_end", 32'(FIFO_EMPTY), 32'd1);

    // saturation then shift
    lanes[0] = 40'h01_0000_0000;
    lanes[1] = 40'h80_0000_0000;
    load_row(2, 0, 1'b1);
    wait_idle("sat");
    drain_all("sat");
    load_row(1, 8, 1'b1);
    wait_idle("shift");
    drain_all("shift");

    // backpressure: four K=5 rows, no reads
    for (int r = 0; r < 4; r++) begin
      rand_lanes();
      load_row(5, int'($urandom_range(0, 31)), 1'b1);
      if (r < 3) wait_idle("bp_row");
    end
    tick();
    tick();
    tick();
    check("bp_full", 32'(FIFO_FULL), 32'd1);
    check("bp_busy", 32'(OS_BUSY), 32'd1);
    for (int p = 0; p < 4; p++) begin
      read_word("bp_pop");
      tick();
      check($sformatf("bp_refill%0d", p), 32'(FIFO_FULL), 32'd1);
    end
    check("bp_busy_done", 32'(OS_BUSY), 32'd0);
    drain_all("bp_order");
    check("bp_empty_end", 32'(FIFO_EMPTY), 32'd1);

    // clear mid-drain
    for (int r = 0; r < 4; r++) begin
      rand_lanes();
      load_row(5, 3, 1'b1);
      if (r < 3) wait_idle("clr_row");
    end
    tick();
    tick();
    check("clr_full", 32'(FIFO_FULL), 32'd1);
    CLEAR_FIFO = 1'b1;
    tick();
    check("clr_empty1", 32'(FIFO_EMPTY), 32'd1);
    check("clr_busy1", 32'(OS_BUSY), 32'd0);
    LOAD_OS = 1'b1;
    tick();
    tick();
    CLEAR_FIFO = 1'b0;
    sbq.delete();
    check("clr_empty", 32'(FIFO_EMPTY), 32'd1);
    check("clr_full0", 32'(FIFO_FULL), 32'd0);
    check("clr_busy", 32'(OS_BUSY), 32'd0);
    check("clr_data", FIFO_RD_DATA, 32'd0);
    tick();
    tick();
    check("clr_noload_busy", 32'(OS_BUSY), 32'd0);
    check("clr_noload_empty", 32'(FIFO_EMPTY), 32'd1);
    LOAD_OS = 1'b0;
    tick();
    lanes[0] = 40'd7;
    load_row(1, 0, 1'b1);
    wait_idle("clr_after");
    drain_all("clr_after");
    check("clr_after_empty", 32'(FIFO_EMPTY), 32'd1);

    // LOAD_OS held for 8 cycles
    rand_lanes();
    PARAM_K = 4'd2;
    PARAM_SHIFT = 5'd1;
    LOAD_OS = 1'b1;
    for (int i = 0; i < 2; i++) sbq.push_back(model(lanes[i], 1));
    repeat (8) tick();
    LOAD_OS = 1'b0;
    tick();
    drain_all("hold");
    check("hold_empty", 32'(FIFO_EMPTY), 32'd1);

    // second load edge during drain is dropped
    rand_lanes();
    load_row(5, 2, 1'b1);
    tick();
    lanes[0] = 40'h00_0000_0BAD;
    LOAD_OS = 1'b1;
    tick();
    LOAD_OS = 1'b0;
    wait_idle("ign");
    tick();
    tick();
    check("ign_busy", 32'(OS_BUSY), 32'd0);
    drain_all("ign");
    check("ign_empty", 32'(FIFO_EMPTY), 32'd1);

    // K=0 is a no-op
    load_row(0, 0, 1'b0);
    check("k0_busy", 32'(OS_BUSY), 32'd0);
    tick();
    tick();
    check("k0_busy2", 32'(OS_BUSY), 32'd0);
    check("k0_empty", 32'(FIFO_EMPTY), 32'd1);

    // K above 5 clamps to 5
    rand_lanes();
    load_row(7, 4, 1'b1);
    wait_idle("k7");
    tick();
    drain_all("k7");
    check("k7_empty", 32'(FIFO_EMPTY), 32'd1);

    // asynchronous reset mid-drain
    rand_lanes();
    load_row(5, 0, 1'b0);
    tick();
    #2;
    RESETN = 1'b0;
    #1;
    check("arst_empty", 32'(FIFO_EMPTY), 32'd1);
    check("arst_busy", 32'(OS_BUSY), 32'd0);
    check("arst_data", FIFO_RD_DATA, 32'd0);
    tick();
    RESETN = 1'b1;
    tick();
    tick();
    check("arst_stay_empty", 32'(FIFO_EMPTY), 32'd1);
    check("arst_stay_idle", 32'(OS_BUSY), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
